// File: rtl/reg_write_bank_pkg.sv
// Shared definitions for the internal 16-bit register bus: register codes,
// default data width and code validity check.
package reg_write_bank_pkg;

    localparam int unsigned BUS_WIDTH = 16;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned NUM_REGS  = 9;

    localparam logic [CODE_W-1:0] CODE_RA = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_RB = 4'b0001;
    localparam logic [CODE_W-1:0] CODE_RC = 4'b0010;
    localparam logic [CODE_W-1:0] CODE_R1 = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_R2 = 4'b0100;
    localparam logic [CODE_W-1:0] CODE_R3 = 4'b0101;
    localparam logic [CODE_W-1:0] CODE_DR = 4'b0110;
    localparam logic [CODE_W-1:0] CODE_AC = 4'b1001;
    localparam logic [CODE_W-1:0] CODE_PC = 4'b1010;

    // Slot index of each register inside the bank
    localparam int unsigned IDX_RA = 0;
    localparam int unsigned IDX_RB = 1;
    localparam int unsigned IDX_RC = 2;
    localparam int unsigned IDX_R1 = 3;
    localparam int unsigned IDX_R2 = 4;
    localparam int unsigned IDX_R3 = 5;
    localparam int unsigned IDX_DR = 6;
    localparam int unsigned IDX_AC = 7;
    localparam int unsigned IDX_PC = 8;

    function automatic logic is_valid_code(input logic [CODE_W-1:0] code);
        case (code)
            CODE_RA, CODE_RB, CODE_RC, CODE_R1, CODE_R2,
            CODE_R3, CODE_DR, CODE_AC, CODE_PC: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] reg_code(input int unsigned idx);
        case (idx)
            IDX_RA:  return CODE_RA;
            IDX_RB:  return CODE_RB;
            IDX_RC:  return CODE_RC;
            IDX_R1:  return CODE_R1;
            IDX_R2:  return CODE_R2;
            IDX_R3:  return CODE_R3;
            IDX_DR:  return CODE_DR;
            IDX_AC:  return CODE_AC;
            IDX_PC:  return CODE_PC;
            default: return CODE_RA;
        endcase
    endfunction

endpackage

// File: rtl/reg_write_bank_reg.sv
// One bank register: clear > load > increment, with registered zero and
// increment-wrap flags that track the register value.
module bus_reg
    import reg_write_bank_pkg::*;
#(
    parameter int unsigned          WIDTH     = BUS_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_zero,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_zero;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Next value; wrap only counts when the increment is the winning op
    always_comb begin
        w_next = r_q;
        w_wrap = 1'b0;
        if (i_clr) begin
            w_next = '0;
        end else if (i_ld) begin
            w_next = i_d;
        end else if (i_inc) begin
            w_next = r_q + WIDTH'(1);
            w_wrap = (r_q == {WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= RESET_VAL;
            r_zero <= (RESET_VAL == '0);
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_next;
            r_zero <= (w_next == '0);
            r_wrap <= w_wrap;
        end
    end

    assign o_q    = r_q;
    assign o_zero = r_zero;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/reg_write_bank.sv
// Write side of the internal data bus: decodes write/increment/clear codes
// into the nine architectural registers and raises selection/wrap flags.
module reg_write_bank
    import reg_write_bank_pkg::*;
#(
    parameter int unsigned      WIDTH    = BUS_WIDTH,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              wr_en,
    input  logic [CODE_W-1:0] wr_sel,
    input  logic              inc_en,
    input  logic [CODE_W-1:0] inc_sel,
    input  logic              clr_en,
    input  logic [CODE_W-1:0] clr_sel,
    output logic [WIDTH-1:0]  ra,
    output logic [WIDTH-1:0]  rb,
    output logic [WIDTH-1:0]  rc,
    output logic [WIDTH-1:0]  r1,
    output logic [WIDTH-1:0]  r2,
    output logic [WIDTH-1:0]  r3,
    output logic [WIDTH-1:0]  dr,
    output logic [WIDTH-1:0]  ac,
    output logic [WIDTH-1:0]  pc,
    output logic              ac_zero,
    output logic              sel_err,
    output logic              pc_wrap
);

    logic [NUM_REGS-1:0] w_wr_hit;
    logic [NUM_REGS-1:0] w_inc_hit;
    logic [NUM_REGS-1:0] w_clr_hit;
    logic [NUM_REGS-1:0] w_zero;
    logic [NUM_REGS-1:0] w_wrap;
    logic [WIDTH-1:0]    w_q [NUM_REGS];
    logic                w_sel_err;
    logic                r_sel_err;
    logic                w_unused_flags;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [CODE_W-1:0] L_CODE  = reg_code(gi);
        localparam logic [WIDTH-1:0]  L_RESET = (gi == IDX_PC) ? PC_RESET : '0;

        assign w_wr_hit[gi]  = wr_en  && (wr_sel  == L_CODE);
        assign w_inc_hit[gi] = inc_en && (inc_sel == L_CODE);
        assign w_clr_hit[gi] = clr_en && (clr_sel == L_CODE);

        bus_reg #(
            .WIDTH     (WIDTH),
            .RESET_VAL (L_RESET)
        ) u_reg (
            .clk    (clk),
            .reset  (reset),
            .i_clr  (w_clr_hit[gi]),
            .i_ld   (w_wr_hit[gi]),
            .i_inc  (w_inc_hit[gi]),
            .i_d    (bus_in),
            .o_q    (w_q[gi]),
            .o_zero (w_zero[gi]),
            .o_wrap (w_wrap[gi])
        );
    end

    // An enabled strobe with an unmapped code matches no slot and is flagged
    always_comb begin
        w_sel_err = 1'b0;
        if (wr_en  && !is_valid_code(wr_sel))  w_sel_err = 1'b1;
        if (inc_en && !is_valid_code(inc_sel)) w_sel_err = 1'b1;
        if (clr_en && !is_valid_code(clr_sel)) w_sel_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_sel_err;
        end
    end

    assign ra      = w_q[IDX_RA];
    assign rb      = w_q[IDX_RB];
    assign rc      = w_q[IDX_RC];
    assign r1      = w_q[IDX_R1];
    assign r2      = w_q[IDX_R2];
    assign r3      = w_q[IDX_R3];
    assign dr      = w_q[IDX_DR];
    assign ac      = w_q[IDX_AC];
    assign pc      = w_q[IDX_PC];
    assign ac_zero = w_zero[IDX_AC];
    assign pc_wrap = w_wrap[IDX_PC];
    assign sel_err = r_sel_err;

    // Only AC's zero flag and PC's wrap flag leave the bank
    assign w_unused_flags = ^{w_zero, w_wrap};

endmodule

// File: tb/tb_reg_write_bank.sv
// Directed plus randomized bench for reg_write_bank against an array-based
// reference model of the register bank.
module tb_reg_write_bank;

    localparam logic [15:0] PC_RST = 16'h0100;

    logic        clk;
    logic        reset;
    logic [15:0] bus_in;
    logic        wr_en, inc_en, clr_en;
    logic [3:0]  wr_sel, inc_sel, clr_sel;
    logic [15:0] ra, rb, rc, r1, r2, r3, dr, ac, pc;
    logic        ac_zero, sel_err, pc_wrap;

    reg_write_bank #(.WIDTH(16), .PC_RESET(PC_RST)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus_in  (bus_in),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .inc_en  (inc_en),
        .inc_sel (inc_sel),
        .clr_en  (clr_en),
        .clr_sel (clr_sel),
        .ra      (ra),
        .rb      (rb),
        .rc      (rc),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .dr      (dr),
        .ac      (ac),
        .pc      (pc),
        .ac_zero (ac_zero),
        .sel_err (sel_err),
        .pc_wrap (pc_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register file indexed by slot, slot order = code table
    logic [3:0]  codes [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA};
    string       names [9] = '{"ra", "rb", "rc", "r1", "r2", "r3", "dr", "ac", "pc"};
    logic [15:0] m_reg [9];
    logic        m_ac_zero, m_sel_err, m_pc_wrap;
    logic [15:0] obs [9];

    int n_pass  = 0;
    int n_total = 0;

    assign obs[0] = ra; assign obs[1] = rb; assign obs[2] = rc;
    assign obs[3] = r1; assign obs[4] = r2; assign obs[5] = r3;
    assign obs[6] = dr; assign obs[7] = ac; assign obs[8] = pc;

    function automatic int slot_of(input logic [3:0] code);
        for (int i = 0; i < 9; i++) if (codes[i] == code) return i;
        return -1;
    endfunction

    // Apply one cycle of strobes to the model as the register bank would see them
    task automatic model_step();
        int ws, is, cs;
        logic [15:0] old_pc;
        if (reset) begin
            for (int i = 0; i < 9; i++) m_reg[i] = 16'h0000;
            m_reg[8]  = PC_RST;
            m_ac_zero = 1'b1;
            m_sel_err = 1'b0;
            m_pc_wrap = 1'b0;
            return;
        end
        ws = wr_en  ? slot_of(wr_sel)  : -1;
        is = inc_en ? slot_of(inc_sel) : -1;
        cs = clr_en ? slot_of(clr_sel) : -1;
        m_sel_err = (wr_en && ws < 0) || (inc_en && is < 0) || (clr_en && cs < 0);
        old_pc = m_reg[8];
        m_pc_wrap = 1'b0;
        if (is >= 0 && is != ws && is != cs) begin
            m_reg[is] = m_reg[is] + 16'd1;
            if (is == 8 && old_pc == 16'hFFFF) m_pc_wrap = 1'b1;
        end
        if (ws >= 0 && ws != cs) m_reg[ws] = bus_in;
        if (cs >= 0) m_reg[cs] = 16'h0000;
        m_ac_zero = (m_reg[7] == 16'h0000);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all();
        for (int i = 0; i < 9; i++) chk(names[i], obs[i], m_reg[i]);
        chk("ac_zero", 16'(ac_zero), 16'(m_ac_zero));
        chk("sel_err", 16'(sel_err), 16'(m_sel_err));
        chk("pc_wrap", 16'(pc_wrap), 16'(m_pc_wrap));
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [3:0] ws, input logic [15:0] bd,
                       input logic ie, input logic [3:0] is, input logic ce, input logic [3:0] cs);
        reset = rst; wr_en = we; wr_sel = ws; bus_in = bd;
        inc_en = ie; inc_sel = is; clr_en = ce; clr_sel = cs;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    initial begin
        // Reset overrides a concurrent DR write
        cyc(1'b1, 1'b1, 4'h6, 16'h1234, 1'b0, 4'h0, 1'b0, 4'h0);
        idle();

        // Write sweep over every valid code
        for (int i = 0; i < 9; i++)
            cyc(1'b0, 1'b1, codes[i], 16'hA000 + 16'(codes[i]), 1'b0, 4'h0, 1'b0, 4'h0);

        // PC increment across the wrap point
        cyc(1'b0, 1'b1, 4'hA, 16'hFFFE, 1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0,    1'b1, 4'hA, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0,    1'b1, 4'hA, 1'b0, 4'h0);
        idle();

        // Priority on AC: clear beats write beats increment
        cyc(1'b0, 1'b1, 4'h9, 16'h0005, 1'b1, 4'h9, 1'b1, 4'h9);
        cyc(1'b0, 1'b1, 4'h9, 16'h0005, 1'b1, 4'h9, 1'b0, 4'h0);
        // Write beats increment on PC at the wrap value: no wrap flag
        cyc(1'b0, 1'b1, 4'hA, 16'hFFFF, 1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'hA, 16'h0010, 1'b1, 4'hA, 1'b0, 4'h0);

        // Parallel write R2 and increment PC
        cyc(1'b0, 1'b1, 4'h4, 16'h00FF, 1'b1, 4'hA, 1'b0, 4'h0);

        // Unmapped write code alongside a valid RA increment
        cyc(1'b0, 1'b1, 4'h0, 16'h0003, 1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h7, 16'hBEEF, 1'b1, 4'h0, 1'b0, 4'h0);
        idle();
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b1, 4'hF);
        idle();

        // Reset in the middle of back-to-back PC increments
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'hA, 1'b0, 4'h0);
        cyc(1'b1, 1'b0, 4'h0, 16'h0, 1'b1, 4'hA, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0, 16'h0, 1'b1, 4'hA, 1'b0, 4'h0);

        // Randomized traffic, codes biased towards the valid map
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  c_w, c_i, c_c;
            logic [15:0] bd;
            c_w = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
            c_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
            c_c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0:       bd = 16'hFFFF;
                1:       bd = 16'h0000;
                default: bd = 16'($urandom);
            endcase
            cyc(($urandom_range(0, 40) == 0), 1'($urandom), c_w, bd,
                1'($urandom), c_i, ($urandom_range(0, 3) == 0), c_c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
